rsg_display_sequencer: RTL
==========================

Name: rsg_display_sequencer

Overview:
- Sequences the Ready/Set/Go countdown on the Basys3 4-digit display, then hands the display to the game datapath.
- Sits between the game core and the seven-segment decoder/mux. It owns the A/B/C/D digit codes and the blank mask.
- Replaces the ad-hoc phase stepping with a timed FSM. Produces a one-cycle go_pulse that starts the game round.

Parameters:
- TICKS_PER_PHASE, 50000000, clk cycles each countdown phase is held (0.5 s at 100 MHz); legal range 2..2^CW-1
- CW, 26, phase timer width; must satisfy 2^CW > TICKS_PER_PHASE

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a countdown; rising-edge detected internally
- abort  in  1  synchronous, level; forces return to IDLE
- game_over  in  1  synchronous, level; game round finished, release display
- game_A, game_B, game_C, game_D  in  4 each  digit codes from game core
- game_blank  in  4  blank mask from game core (bit3=A .. bit0=D, 1=blank)
- A, B, C, D  out  4 each  digit codes to display decoder
- blank  out  4  blank mask to display mux
- phase  out  3  0=IDLE 1=READY 2=SET 3=GO 4=GAME
- go_pulse  out  1  single-cycle strobe on entry to GAME
- busy  out  1  high in READY, SET, GO, GAME

Behaviour:
- Reset (async, any time, including mid-countdown):
  - state=IDLE, timer=0, start_q=1, go_pulse=0.
  - Outputs read A=B=C=D=0, blank=4'b1111, phase=0, busy=0 while reset is held and after release.
- Start detection:
  - start_q is a register of start. start_rise = start & ~start_q.
  - Because start_q resets to 1, start held high through reset release does not trigger.
- States and transitions, evaluated at posedge clk, priority top to bottom:
  - abort=1: any state -> IDLE; timer=0.
  - IDLE: start_rise -> READY; timer=0.
  - READY / SET / GO: timer increments each cycle. When timer==TICKS_PER_PHASE-1, advance (READY->SET->GO->GAME) and clear timer. Each phase therefore lasts exactly TICKS_PER_PHASE cycles.
  - GAME: game_over=1 -> IDLE; otherwise hold. The timer stays at 0.
  - start_rise outside IDLE is ignored, not queued.
- Simultaneous events:
  - abort beats timer expiry, start_rise and game_over.
  - game_over outside GAME is ignored.
  - start_rise on the same edge that GAME->IDLE occurs is ignored. A new rising edge is required.
- Output decode (combinational from state register; GAME path is combinational from game_* inputs):
  - IDLE: A=B=C=D=0, blank=1111.
  - READY: A=0, B=4'hA, C=4'h4, D=4'hC, blank=1000.
  - SET: A=0, B=0, C=4'hB, D=4'hE, blank=1100.
  - GO: A=0, B=0, C=4'hD, D=4'h0, blank=1100.
  - GAME: A..D=game_A..game_D, blank=game_blank.
- go_pulse:
  - Registered. High for exactly the first cycle phase==4, i.e. the cycle after the GO->GAME edge, when it is set together with the state.
  - Never high in any other cycle.
- Timer has no wrap: it is cleared on every phase change, so the max value is TICKS_PER_PHASE-1.
- Latency:
  - start rising at cycle n (sampled at edge n) -> phase=1 from cycle n+1.
  - go_pulse at cycle n+1+3*TICKS_PER_PHASE.
- No latches: every output is assigned in every state.

Test Plan (TICKS_PER_PHASE=4, CW=3):
- Reset then start pulse 1 cycle -> phase 1 for 4 cycles (B=A, C=4, D=C, blank=1000), phase 2 for 4 (C=B, D=E, blank=1100), phase 3 for 4, then phase 4 with go_pulse=1 for exactly 1 cycle; busy=1 throughout.
- In GAME drive game_A..D=1,2,3,4 and game_blank=0000 -> outputs match inputs same cycle. Assert game_over -> next cycle phase=0, blank=1111, busy=0.
- Assert abort in SET at timer=2 -> next cycle IDLE, blank=1111. Then a new start pulse -> full 4-cycle READY again (timer restarted).
- Hold start high across reset release -> stays IDLE. Drop and re-raise start -> READY next cycle. Re-pulse start during READY/SET -> no phase restart, timing unchanged.
- Async reset pulse mid-GO (between clock edges) -> outputs IDLE immediately, no go_pulse afterwards.
- abort and timer expiry on the same edge in GO -> IDLE, go_pulse stays 0. game_over held high from the start pulse onward -> countdown unaffected, then exits GAME one cycle after entry, with go_pulse still 1 cycle.

Source files
------------

// File: rtl/rsg_display_sequencer.sv
// Ready/Set/Go countdown sequencer for the 4-digit display. It owns the
// A-D digit codes and the blank mask until the countdown completes, then
// passes the game core's digits straight through.
// Latency: a start rising edge sampled at edge n gives phase=1 from cycle n+1.
// go_pulse is high in cycle n+1+3*TICKS_PER_PHASE.
// Backpressure: none. abort and game_over are synchronous levels, and start
// is edge-detected.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   start                countdown request (rising edge)
//   abort                return to IDLE from any state
//   game_over            leave GAME and release the display
//   game_A..D, game_blank  display contents from the game core
//   A..D, blank          display contents to the decoder/mux
//   phase                0=IDLE 1=READY 2=SET 3=GO 4=GAME
//   go_pulse             one-cycle strobe in the first GAME cycle
//   busy                 high in every state except IDLE
module rsg_display_sequencer #(
    parameter int TICKS_PER_PHASE = 50000000,
    parameter int CW              = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       game_over,
    input  logic [3:0] game_A,
    input  logic [3:0] game_B,
    input  logic [3:0] game_C,
    input  logic [3:0] game_D,
    input  logic [3:0] game_blank,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic [3:0] blank,
    output logic [2:0] phase,
    output logic       go_pulse,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_SET   = 3'd2;
    localparam logic [2:0] S_GO    = 3'd3;
    localparam logic [2:0] S_GAME  = 3'd4;

    localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_PHASE - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          start_q, start_d;
    logic          go_pulse_q, go_pulse_d;
    logic          start_rise;

    // start_q resets high, so a start that is held through reset release is not
    // seen as a new request.
    assign start_rise = start & ~start_q;
    assign start_d    = start;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        go_pulse_d = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_d = '0;
                    if (start_rise) begin
                        state_d = S_READY;
                    end
                end
                S_READY, S_SET, S_GO: begin
                    if (timer_q == LAST_TICK) begin
                        state_d = state_q + 3'd1;
                        timer_d = '0;
                        // The strobe is registered together with the GAME state,
                        // so it lines up with the first GAME cycle.
                        go_pulse_d = (state_q == S_GO);
                    end else begin
                        timer_d = timer_q + CW'(1);
                    end
                end
                S_GAME: begin
                    timer_d = '0;
                    if (game_over) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            start_q    <= 1'b1;
            go_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            start_q    <= start_d;
            go_pulse_q <= go_pulse_d;
        end
    end

    // Digit codes spell the prompt on the display. In GAME the game core drives
    // the display combinationally.
    always_comb begin
        A     = 4'h0;
        B     = 4'h0;
        C     = 4'h0;
        D     = 4'h0;
        blank = 4'b1111;
        case (state_q)
            S_READY: begin
                B     = 4'hA;
                C     = 4'h4;
                D     = 4'hC;
                blank = 4'b1000;
            end
            S_SET: begin
                C     = 4'hB;
                D     = 4'hE;
                blank = 4'b1100;
            end
            S_GO: begin
                C     = 4'hD;
                D     = 4'h0;
                blank = 4'b1100;
            end
            S_GAME: begin
                A     = game_A;
                B     = game_B;
                C     = game_C;
                D     = game_D;
                blank = game_blank;
            end
            default: begin
                blank = 4'b1111;
            end
        endcase
    end

    assign phase    = state_q;
    assign go_pulse = go_pulse_q;
    assign busy     = (state_q != S_IDLE);

endmodule
